// File: rtl/ddsm_rx_pkg.sv
// ddsm_rx_pkg: shared constants and width helpers for the DDSM receive-side CIC decimator
package ddsm_rx_pkg;
   localparam int CIC_ORDER = 3;
   // Integrator/comb width: input width plus the bit growth of the order-3 DC gain R^3
   function automatic int acc_w(input int in_w, input int log2_r);
      return in_w + CIC_ORDER * log2_r;
   endfunction
   // Right shift that maps the R^3 gain onto the requested fractional bits
   function automatic int shift_w(input int log2_r, input int frac);
      return CIC_ORDER * log2_r - frac;
   endfunction
   function automatic bit params_ok(input int in_w, input int out_w, input int frac, input int log2_r);
      return (out_w >= in_w + frac) && (CIC_ORDER * log2_r >= frac);
   endfunction
endpackage

// File: rtl/ddsm_cic_integrator.sv
// ddsm_cic_integrator: enable-gated modulo-2^W accumulator (one CIC integrator stage)
//   clk, rst (async, active high), clr (sync clear), en (advance), d (addend), q (running sum)
module ddsm_cic_integrator #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // Wrap-around is intentional; the comb differences cancel it.
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= q + d;
endmodule

// File: rtl/ddsm_cic_decimator.sv
// ddsm_cic_decimator: order-3 CIC decimator rebuilding the Q3.9 word from a MASH 1-1-1 DDSM stream
//   clk, rst (async, active high), clr (sync clear)
//   in_valid/in_data: signed DDSM samples (-3..+4)
//   out_valid: one-cycle strobe per decimated result, out_data: signed result held between strobes
module ddsm_cic_decimator
   import ddsm_rx_pkg::*;
#(
   parameter int IN_WIDTH        = 4,
   parameter int OUT_WIDTH       = 13,
   parameter int fractional_bits = 9,
   parameter int LOG2_R          = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data
);
   localparam int ACC_W = acc_w(IN_WIDTH, LOG2_R);
   localparam int SHIFT = shift_w(LOG2_R, fractional_bits);

   if (!params_ok(IN_WIDTH, OUT_WIDTH, fractional_bits, LOG2_R)) begin : g_bad_params
      $error("ddsm_cic_decimator: need OUT_WIDTH >= IN_WIDTH+fractional_bits and 3*LOG2_R >= fractional_bits");
   end

   logic [ACC_W-1:0] x, i1, i2, i3;
   logic [ACC_W-1:0] c1, c2, d1, d2, d3;
   logic signed [ACC_W-1:0] y;
   logic [LOG2_R-1:0] cnt;
   logic [1:0] wu;
   logic dec_stb, v1, v2;

   assign x = {{(ACC_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
   // Floor (arithmetic) shift of the final comb difference
   assign y = $signed(c2 - d3) >>> SHIFT;

   // Each stage adds the previous stage's registered value, forming a registered chain
   ddsm_cic_integrator #(.W(ACC_W)) u_int1 (.clk(clk), .rst(rst), .clr(clr), .en(in_valid), .d(x),  .q(i1));
   ddsm_cic_integrator #(.W(ACC_W)) u_int2 (.clk(clk), .rst(rst), .clr(clr), .en(in_valid), .d(i1), .q(i2));
   ddsm_cic_integrator #(.W(ACC_W)) u_int3 (.clk(clk), .rst(rst), .clr(clr), .en(in_valid), .d(i2), .q(i3));

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0; dec_stb <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; wu <= '0;
         c1 <= '0; c2 <= '0; d1 <= '0; d2 <= '0; d3 <= '0;
         out_valid <= 1'b0; out_data <= '0;
      end else if (clr) begin
         cnt <= '0; dec_stb <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; wu <= '0;
         c1 <= '0; c2 <= '0; d1 <= '0; d2 <= '0; d3 <= '0;
         out_valid <= 1'b0; out_data <= '0;
      end else begin
         // R is a power of two, so the counter wraps at R-1 by itself
         if (in_valid) cnt <= cnt + LOG2_R'(1);
         dec_stb <= in_valid && (&cnt);
         v1 <= dec_stb;
         v2 <= v1;
         if (dec_stb) begin
            c1 <= i3 - d1;
            d1 <= i3;
         end
         if (v1) begin
            c2 <= c1 - d2;
            d2 <= c1;
         end
         // The first three results carry the comb start-up transient and stay unflagged
         out_valid <= v2 && (&wu);
         if (v2) begin
            out_data <= OUT_WIDTH'(y);
            d3 <= c2;
            if (!(&wu)) wu <= wu + 2'd1;
         end
      end
endmodule

// File: doc/ddsm_cic_decimator.md
Name: ddsm_cic_decimator

Overview:
- Receive-side counterpart of the Tx MASH 1-1-1 delta-sigma modulator.
- Takes the 4-bit signed noise-cancelled DDSM stream (values -3..+4) and reconstructs the 13-bit Q3.9 word with a 3rd-order CIC (sinc^3) decimator.
- Used in loopback/Rx paths to recover the modulator input at the decimated rate.

Parameters:
- IN_WIDTH, 4: signed DDSM sample width.
- OUT_WIDTH, 13: signed output width. Must be >= IN_WIDTH+fractional_bits.
- fractional_bits, 9: output fractional bits. Output LSB = 2^-fractional_bits.
- LOG2_R, 4: log2 of the decimation ratio (R = 16). Requires 3*LOG2_R >= fractional_bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous clear; same effect as reset, takes effect at the next edge
- in_valid  in  1  in_data is a valid modulator sample this cycle
- in_data  in  IN_WIDTH  signed two's-complement DDSM sample
- out_valid  out  1  one-cycle strobe; out_data valid
- out_data  out  OUT_WIDTH  signed decimated result, Q(OUT_WIDTH-fractional_bits).fractional_bits

Behaviour:
- Reset/clr: clear every integrator, comb delay, decimation counter, valid pipe and warm-up counter. out_valid=0 and out_data=0. rst is asynchronous; clr is synchronous and has priority over in_valid in the same cycle.
- Internal width ACC_W = IN_WIDTH + 3*LOG2_R (16). in_data is sign-extended to ACC_W.
- Integrators advance only when in_valid=1, as a registered chain:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- All integrator and comb arithmetic is modulo 2^ACC_W. Wrap-around is required and must not saturate; the comb differences cancel it.
- Decimation counter: 0..R-1, increments on in_valid and wraps at R-1. When in_valid=1 and count==R-1, dec_stb is registered high for exactly one cycle. Gaps in in_valid stall the counter and the integrators.
- Comb pipeline, one register stage each, with a valid bit following dec_stb:
  - on dec_stb: c1 <= i3 - d1, d1 <= i3
  - next cycle: c2 <= c1 - d2, d2 <= c1
  - next cycle: out_data <= (c2 - d3) >>> SHIFT, d3 <= c2
  - SHIFT = 3*LOG2_R - fractional_bits (3).
- Scaling: DC gain R^3 = 2^12, so constant input x gives out_data = x*2^fractional_bits (x=1 -> 512 = 1.0). Shift is arithmetic truncation (floor), not rounding. The result is sign-extended to OUT_WIDTH. No overflow is possible for inputs in -3..+4.
- Latency: if the R-th accepted sample is in cycle t, out_valid=1 in cycle t+4 for one cycle. out_data holds its value until the next update.
- Warm-up: a 2-bit counter suppresses out_valid for the first 3 decimated results after reset/clr. The comb registers still update on those results. From the 4th result on, out_valid is asserted on every decimated result.
- Back-to-back: in_valid continuously high gives one out_valid every R cycles. No backpressure.
- Reset or clr mid-window or mid-pipeline discards the in-flight result; no out_valid follows.

Decomposition:
- Package ddsm_rx_pkg holds:
  - CIC_ORDER = 3
  - functions/constants for ACC_W and SHIFT, derived from IN_WIDTH, LOG2_R, fractional_bits
  - elaboration-time checks on the parameter constraints
- One natural sub-module: ddsm_cic_integrator (enable-gated modulo accumulator, width ACC_W), instantiated 3 times. Comb stages stay inline in the top.

Test Plan:
- Constant in_data=1, in_valid=1 from reset, R=16: first out_valid at cycle 4*16+4 after release (4th result). out_data=512 on every strobe, one strobe per 16 cycles.
- Constant in_data=-3 -> out_data=-1536. Constant +4 -> 2048. Confirms sign extension and the extreme positive code.
- Alternating +1/0 every sample -> 256 (0.5). Pattern +1,+1,+1,-3 repeating -> 0. Confirms averaging and the modulo/cancellation path.
- in_valid toggled 1-0-1-0 with in_data=2 -> out_data=1024 with strobe spacing 32 cycles. Samples presented while in_valid=0 (e.g. 7) have no effect.
- Long run (>=5000 samples) of +4 to force integrator wrap-around -> out_data stays exactly 2048 on every strobe.
- Assert clr (and separately rst) at count=9 mid-window -> no out_valid for the in-flight window; the 3-result warm-up repeats; then correct values resume.
